// File: rtl/idct_row_seq.sv
// idct_row_seq
// Sequencer between a coefficient stream and the row-IDCT engine window.
// Each row of eight coefficients is written into the engine. The engine is then
// polled once per element, and each result is streamed out over a valid/ready
// handshake.
// Optional feature: define IDCT_SEQ_TIMEOUT_EN to build the WAIT timeout and the
// sticky err flag. Without it, WAIT holds until the engine answers and err is 0.

module idct_row_seq #(
   parameter logic [31:0] BASE_ADDR      = 32'h4200_0000,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_inValid,
   output logic        o_inReady,
   input  logic [15:0] i_inData,
   output logic        o_outValid,
   input  logic        i_outReady,
   output logic [15:0] o_outData,
   output logic        o_outLast,
   output logic        o_engValidWrite,
   output logic [31:0] o_engWaddr,
   output logic [15:0] o_engWdata,
   output logic [31:0] o_engRaddr,
   input  logic [15:0] i_engRdata,
   input  logic        i_engRrdy,
   output logic        o_blockDone,
   output logic        o_err,
   input  logic        i_errClr
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } seqState_t;

   seqState_t   r_state;
   seqState_t   w_nextState;

   logic [2:0]  r_row;
   logic [2:0]  r_col;

   logic        r_engValidWrite;
   logic [31:0] r_engWaddr;
   logic [15:0] r_engWdata;
   logic [31:0] r_engRaddr;

   logic [15:0] r_outData;
   logic        r_outValid;
   logic        r_blockDone;

   logic        w_inFire;
   logic        w_outFire;
   logic        w_readDone;
   logic        w_timeout;
   logic        w_lastCol;
   logic        w_lastRow;

   // Engine address of element (row, col). The element offset is at most 8'hFC.
   // It is added into the low byte only, so the upper 24 bits of the window
   // base never change, whatever base the window is placed at.
   function automatic logic [31:0] elemAddr(input logic [2:0] rowIdx, input logic [2:0] colIdx);
      logic [7:0] offset;
      offset   = {rowIdx, colIdx, 2'b00};
      elemAddr = {BASE_ADDR[31:8], BASE_ADDR[7:0] + offset};
   endfunction

   assign w_lastCol = (r_col == 3'd7);
   assign w_lastRow = (r_row == 3'd7);

   // Next-state logic and the per-cycle strobes.
   // LOAD accepts one coefficient per cycle until the eighth one is taken.
   // WAIT leaves as soon as the engine answers, or when the timeout fires.
   // OUT holds until the consumer takes the word, then either polls the next
   // element or goes back to loading.
   always_comb begin
      w_nextState = r_state;
      w_inFire    = 1'b0;
      w_outFire   = 1'b0;
      w_readDone  = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_inFire = i_inValid;
            if (i_inValid && w_lastCol) begin
               w_nextState = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_readDone = i_engRrdy || w_timeout;
            if (w_readDone) begin
               w_nextState = ST_OUT;
            end
         end
         ST_OUT: begin
            w_outFire = r_outValid && i_outReady;
            if (w_outFire) begin
               w_nextState = w_lastCol ? ST_LOAD : ST_WAIT;
            end
         end
         default: begin
            w_nextState = ST_LOAD;
         end
      endcase
   end

   // State register. A reset drops any partial row on the floor; the engine is
   // never told, and the next accepted coefficient is element 0 again.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Row and column counters within the 8x8 block.
   // The column advances once per accepted coefficient and once per delivered
   // result, so it sweeps 0..7 twice per row. The row advances only after the
   // eighth result of the row has been taken.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else begin
         if (w_inFire) begin
            r_col <= r_col + 3'd1;
         end else if (w_outFire) begin
            r_col <= r_col + 3'd1;
            if (w_lastCol) begin
               r_row <= r_row + 3'd1;
            end
         end
      end
   end

   // Engine write port. The data and address registers hold the last written
   // element. The strobe is high for exactly the one cycle after each input
   // handshake, so a back-to-back load produces eight consecutive pulses.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_engValidWrite <= 1'b0;
         r_engWaddr      <= BASE_ADDR;
         r_engWdata      <= 16'h0000;
      end else begin
         r_engValidWrite <= w_inFire;
         if (w_inFire) begin
            r_engWaddr <= elemAddr(r_row, r_col);
            r_engWdata <= i_inData;
         end
      end
   end

   // Engine read address. It is set up on the edge that enters WAIT, so the
   // engine's ready flag is only ever judged against an address that was
   // already stable for a full cycle. It holds while OUT is stalled.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_engRaddr <= BASE_ADDR;
      end else begin
         if (w_inFire && w_lastCol) begin
            r_engRaddr <= elemAddr(r_row, 3'd0);
         end else if (w_outFire && !w_lastCol) begin
            r_engRaddr <= elemAddr(r_row, r_col + 3'd1);
         end
      end
   end

   // Result holding register. It captures the engine word when the engine
   // answers, or zero when the wait timed out, and then holds it stable until
   // the consumer accepts it.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_outData  <= 16'h0000;
         r_outValid <= 1'b0;
      end else begin
         if (w_readDone) begin
            r_outData  <= i_engRrdy ? i_engRdata : 16'h0000;
            r_outValid <= 1'b1;
         end else if (w_outFire) begin
            r_outValid <= 1'b0;
         end
      end
   end

   // Block completion pulse. It fires on the cycle after element 63 has been
   // handed to the consumer.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_blockDone <= 1'b0;
      end else begin
         r_blockDone <= w_outFire && w_lastCol && w_lastRow;
      end
   end

`ifdef IDCT_SEQ_TIMEOUT_EN
   logic [7:0] r_waitCnt;
   logic       r_err;

   // Wait-cycle counter. It counts WAIT cycles in which the engine has not
   // answered, and is cleared whenever the sequencer is outside WAIT, so every
   // element poll starts from zero.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_waitCnt <= 8'd0;
      end else begin
         if (r_state != ST_WAIT) begin
            r_waitCnt <= 8'd0;
         end else if (!i_engRrdy) begin
            r_waitCnt <= r_waitCnt + 8'd1;
         end
      end
   end

   assign w_timeout = (r_state == ST_WAIT) && !i_engRrdy &&
                      (r_waitCnt == TIMEOUT_CYCLES - 8'd1);

   // Sticky error flag. A timeout on the same edge as a clear request wins, so
   // a fresh loss is never hidden by a clear that was meant for an older one.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_err <= 1'b0;
      end else begin
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (i_errClr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign o_err = r_err;
`else
   logic [8:0] w_unusedCfg;

   assign w_unusedCfg = {i_errClr, TIMEOUT_CYCLES};
   assign w_timeout   = 1'b0;
   assign o_err       = 1'b0;
`endif

   assign o_inReady       = (r_state == ST_LOAD);
   assign o_outValid      = r_outValid;
   assign o_outData       = r_outData;
   assign o_outLast       = r_outValid && w_lastRow && w_lastCol;
   assign o_engValidWrite = r_engValidWrite;
   assign o_engWaddr      = r_engWaddr;
   assign o_engWdata      = r_engWdata;
   assign o_engRaddr      = r_engRaddr;
   assign o_blockDone     = r_blockDone;

endmodule
